// File: rtl/serial_mem_bridge_pkg.sv
// rtl/serial_mem_bridge_pkg.sv - shared types and constants for the serial memory bridge
package serial_mem_bridge_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 16;
    localparam int HDR_LEN    = 1 + ADDR_W_DEF;
    localparam int CNT_W      = $clog2(DATA_W_DEF + 1);

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        WDATA = 3'd2,
        ACC   = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/serial_mem_bridge_if.sv
// rtl/serial_mem_bridge_if.sv - register-memory port between bridge and memory
interface serial_mem_bridge_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 16
);
    logic              mem_sel;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_sel,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_sel,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/serial_mem_bridge_sr_shifter.sv
// rtl/serial_mem_bridge_sr_shifter.sv - DATA_W-wide SIPO/PISO shift register
module sr_shifter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              shift_en,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              serial_in,
    output logic              msb_out,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] sr;

    // parallel load wins over shift; shifting moves towards the MSB
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift_en) begin
            sr <= {sr[DATA_W-2:0], serial_in};
        end
    end

    assign msb_out = sr[DATA_W-1];
    assign data    = sr;

endmodule

// File: rtl/serial_mem_bridge.sv
// rtl/serial_mem_bridge.sv - bit-serial command frames to a single-cycle memory access
module serial_mem_bridge
    import serial_mem_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cs_n,
    input  logic                bit_en,
    input  logic                sdi,
    output logic                sdo,
    output logic                busy,
    output logic                done,
    output logic                frame_err,
    serial_mem_bridge_if.master mem
);

    localparam int HDR_BITS = 1 + ADDR_W;
    localparam int CNT_BITS = $clog2(DATA_W + 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_BITS-1:0] cnt;
    logic                cs_n_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                sel_q;
    logic                wr_q;

    logic                bit_ok;
    logic                frame_start;
    logic                hdr_last;
    logic                wdata_last;
    logic                rdata_last;
    logic [HDR_BITS-1:0] hdr_word;
    logic [DATA_W-1:0]   wdata_word;
    logic                hdr_rw;
    logic                rw_next;

    logic                sr_shift;
    logic                sr_load;
    logic [DATA_W-1:0]   sr_load_data;
    logic                sr_in;
    logic                sr_msb;
    logic [DATA_W-1:0]   sr_data;

    logic                sel_d;
    logic                wr_d;
    logic                done_d;
    logic                err_d;
    logic                sdo_d;

    sr_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk       (clk),
        .rstn      (rstn),
        .shift_en  (sr_shift),
        .load      (sr_load),
        .load_data (sr_load_data),
        .serial_in (sr_in),
        .msb_out   (sr_msb),
        .data      (sr_data)
    );

    assign bit_ok      = bit_en & ~cs_n;
    assign frame_start = ~cs_n & cs_n_q;
    assign hdr_last    = (state == HDR)   && bit_ok && (cnt == CNT_BITS'(HDR_BITS - 1));
    assign wdata_last  = (state == WDATA) && bit_ok && (cnt == CNT_BITS'(DATA_W - 1));
    assign rdata_last  = (state == RDATA) && bit_ok && (cnt == CNT_BITS'(DATA_W - 1));

    // the last header/data bit is still on sdi, so the latched words include it directly
    assign hdr_word    = {sr_data[HDR_BITS-2:0], sdi};
    assign wdata_word  = {sr_data[DATA_W-2:0], sdi};
    assign hdr_rw      = hdr_word[HDR_BITS-1];
    assign rw_next     = (state == HDR) ? hdr_rw : rw_q;

    // shifter: sdi in during header/write data, zero fill while reading out
    assign sr_shift     = bit_ok && ((state == HDR) || (state == WDATA) || (state == RDATA));
    assign sr_in        = (state == RDATA) ? 1'b0 : sdi;
    assign sr_load      = ((state == ACC) && (rw_q == RW_READ)) || ((state == IDLE) && frame_start);
    assign sr_load_data = (state == ACC) ? mem.mem_rdata : '0;

    assign busy          = (state != IDLE);
    assign mem.mem_sel   = sel_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state: cs_n high aborts every active state; DONE just waits for cs_n
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = HDR;
            HDR: begin
                if (cs_n)          state_next = IDLE;
                else if (hdr_last) state_next = (hdr_rw == RW_WRITE) ? WDATA : ACC;
            end
            WDATA: begin
                if (cs_n)            state_next = IDLE;
                else if (wdata_last) state_next = ACC;
            end
            ACC: begin
                if (cs_n) state_next = IDLE;
                else      state_next = (rw_q == RW_WRITE) ? DONE : RDATA;
            end
            RDATA: begin
                if (cs_n)            state_next = IDLE;
                else if (rdata_last) state_next = DONE;
            end
            DONE:    if (cs_n) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // output decode: next values for the registered outputs
    always_comb begin
        sel_d  = (state_next == ACC);
        wr_d   = sel_d & rw_next;
        done_d = (state_next == DONE) && (state != DONE);
        err_d  = cs_n && ((state == HDR) || (state == WDATA) || (state == ACC) || (state == RDATA));
        sdo_d  = 1'b0;
        if ((state == ACC) && (state_next == RDATA)) begin
            sdo_d = mem.mem_rdata[DATA_W-1];
        end else if ((state == RDATA) && (state_next == RDATA)) begin
            sdo_d = bit_ok ? sr_data[DATA_W-2] : sdo;
        end
    end

    // output registers keep mem_sel/mem_wr and the pulses glitch-free
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_q     <= 1'b0;
            wr_q      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            sdo       <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            wr_q      <= wr_d;
            done      <= done_d;
            frame_err <= err_d;
            sdo       <= sdo_d;
        end
    end

    // bit counter (cleared on every state change), frame-select history and latched fields
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            cs_n_q  <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cs_n_q <= cs_n;
            if (state_next != state) begin
                cnt <= '0;
            end else if (sr_shift) begin
                cnt <= cnt + CNT_BITS'(1);
            end
            if (hdr_last) begin
                rw_q   <= hdr_rw;
                addr_q <= hdr_word[ADDR_W-1:0];
            end
            if (wdata_last) begin
                wdata_q <= wdata_word;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = sr_msb;

endmodule
